// File: rtl/gemm_pkg.sv
// Shared GEMM definitions: drain FSM state encoding and the requantize/saturate helper.
package gemm_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } drain_state_e;

   // Working width for requantization. It holds any accumulator up to 64 bits
   // sign-extended, plus one bit of headroom for the rounding add.
   localparam int QW = 65;

   // Round-half-up arithmetic right shift by 'shift', then clamp to a signed
   // out_w-bit range. The caller sign-extends acc to QW bits; the result is
   // still QW bits wide and only its low out_w bits are meaningful.
   function automatic logic signed [QW-1:0] requant_sat(
      input logic signed [QW-1:0] acc,
      input int                   shift,
      input int                   out_w
   );
      logic signed [QW-1:0] rnd;
      logic signed [QW-1:0] t;
      logic signed [QW-1:0] hi;
      logic signed [QW-1:0] lo;
      rnd = (shift > 0) ? (QW'(1) << (shift - 1)) : '0;
      t   = (acc + rnd) >>> shift;
      hi  = (QW'(1) << (out_w - 1)) - QW'(1);
      lo  = ~hi;
      if (t > hi)      t = hi;
      else if (t < lo) t = lo;
      return t;
   endfunction

endpackage

// File: rtl/sa_output_drain.sv
// Captures a finished systolic-array C matrix and streams it out one element
// per beat, in row-major order and requantized, under valid/ready flow control.
module sa_output_drain
   import gemm_pkg::*;
#(
   parameter int M         = 4,
   parameter int N         = 4,
   parameter int ACC_WIDTH = 32,
   parameter int OUT_WIDTH = 8,
   parameter int SHIFT     = 0,
   localparam int RW       = (M > 1) ? $clog2(M) : 1,
   localparam int CW       = (N > 1) ? $clog2(N) : 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     cap_valid,
   output logic                     cap_ready,
   input  logic [M*N*ACC_WIDTH-1:0] c_flat,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_WIDTH-1:0]     out_data,
   output logic [RW-1:0]            out_row,
   output logic [CW-1:0]            out_col,
   output logic                     out_last,
   output logic                     busy
);

   localparam int LW = (M * N > 1) ? $clog2(M * N) : 1;

   drain_state_e                state_q, state_d;
   logic [RW-1:0]               row_q;
   logic [CW-1:0]               col_q;
   logic [LW-1:0]               lin_q;     // row_q*N + col_q, kept as its own counter for buffer indexing
   logic signed [ACC_WIDTH-1:0] mat_q [M*N];
   logic                        cap_fire;
   logic                        beat_fire;
   logic                        at_last;
   logic signed [OUT_WIDTH-1:0] q_elem;

   assign at_last   = (row_q == RW'(M - 1)) && (col_q == CW'(N - 1));
   assign cap_fire  = cap_valid && cap_ready;
   assign beat_fire = out_valid && out_ready;

   // Next-state and handshake outputs; capture is only possible in IDLE, so a
   // cap_valid seen while streaming (including on the last beat) is dropped.
   always_comb begin
      state_d   = state_q;
      cap_ready = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cap_ready = 1'b1;
            if (cap_valid) state_d = ST_STREAM;
         end
         ST_STREAM: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready && at_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; reset abandons any matrix in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Row/column walk: column fastest, everything back to zero after the last beat.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_q <= '0;
         col_q <= '0;
         lin_q <= '0;
      end else if (cap_fire || (beat_fire && at_last)) begin
         row_q <= '0;
         col_q <= '0;
         lin_q <= '0;
      end else if (beat_fire) begin
         lin_q <= lin_q + LW'(1);
         if (col_q == CW'(N - 1)) begin
            col_q <= '0;
            row_q <= row_q + RW'(1);
         end else begin
            col_q <= col_q + CW'(1);
         end
      end
   end

   // Matrix snapshot taken on the capture handshake; contents are don't-care until then.
   always_ff @(posedge clk) begin
      if (cap_fire) begin
         for (int i = 0; i < M * N; i++) mat_q[i] <= c_flat[i*ACC_WIDTH +: ACC_WIDTH];
      end
   end

   // Requantize the element under the cursor.
   always_comb begin
      q_elem = OUT_WIDTH'(requant_sat(QW'(mat_q[lin_q]), SHIFT, OUT_WIDTH));
   end

   // Data is forced to zero outside STREAM so that reset and idle read as 0.
   assign out_data = (state_q == ST_STREAM) ? q_elem : '0;
   assign out_row  = row_q;
   assign out_col  = col_q;
   assign out_last = (state_q == ST_STREAM) && at_last;

endmodule

// File: tb/tb_sa_output_drain.sv
// Directed bench for sa_output_drain: three parameterizations, a scoreboard
// queue per instance, and immediate-assertion checks at every comparison point.
module tb_sa_output_drain;

   typedef struct {
      longint data;
      int     row;
      int     col;
      bit     last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   beat_t sb_a[$];
   beat_t sb_b[$];
   beat_t sb_c[$];

   // Instance A: 4x4, pass-through, 32-bit output
   logic               a_cap_valid, a_cap_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
   logic [16*32-1:0]   a_c_flat;
   logic signed [31:0] a_out_data;
   logic [1:0]         a_out_row, a_out_col;

   sa_output_drain #(.M(4), .N(4), .ACC_WIDTH(32), .OUT_WIDTH(32), .SHIFT(0)) u_a (
      .clk(clk), .reset_n(rst_n), .cap_valid(a_cap_valid), .cap_ready(a_cap_ready),
      .c_flat(a_c_flat), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .out_row(a_out_row), .out_col(a_out_col),
      .out_last(a_out_last), .busy(a_busy));

   // Instance B: 1x4, SHIFT=2, 8-bit saturating output
   logic              b_cap_valid, b_cap_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
   logic [4*32-1:0]   b_c_flat;
   logic signed [7:0] b_out_data;
   logic [0:0]        b_out_row;
   logic [1:0]        b_out_col;

   sa_output_drain #(.M(1), .N(4), .ACC_WIDTH(32), .OUT_WIDTH(8), .SHIFT(2)) u_b (
      .clk(clk), .reset_n(rst_n), .cap_valid(b_cap_valid), .cap_ready(b_cap_ready),
      .c_flat(b_c_flat), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .out_row(b_out_row), .out_col(b_out_col),
      .out_last(b_out_last), .busy(b_busy));

   // Instance C: 1x3, pass-through, 16-bit
   logic               c_cap_valid, c_cap_ready, c_out_valid, c_out_ready, c_out_last, c_busy;
   logic [3*16-1:0]    c_c_flat;
   logic signed [15:0] c_out_data;
   logic [0:0]         c_out_row;
   logic [1:0]         c_out_col;

   sa_output_drain #(.M(1), .N(3), .ACC_WIDTH(16), .OUT_WIDTH(16), .SHIFT(0)) u_c (
      .clk(clk), .reset_n(rst_n), .cap_valid(c_cap_valid), .cap_ready(c_cap_ready),
      .c_flat(c_c_flat), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_data(c_out_data), .out_row(c_out_row), .out_col(c_out_col),
      .out_last(c_out_last), .busy(c_busy));

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Fill A's input with base + i*step and queue the expected beats.
   task automatic load_a(input int base, input int step);
      int v;
      for (int i = 0; i < 16; i++) begin
         v = base + i * step;
         a_c_flat[i*32 +: 32] = v;
         sb_a.push_back('{data: longint'(v), row: i / 4, col: i % 4, last: (i == 15)});
      end
   endtask

   task automatic cap_a();
      @(negedge clk);
      chk("a_cap_ready_idle", a_cap_ready, 1);
      a_cap_valid = 1'b1;
   endtask

   // Drain A against the scoreboard. stall_pat applies out_ready 1,0,0,1;
   // inject pulses cap_valid with a different matrix mid-stream and on the last beat.
   task automatic drain_a(input bit stall_pat, input bit inject, input int stop_beats,
                          output int cyc, output int beats);
      beat_t  e;
      bit     stalled, rdy;
      longint pd;
      int     pr, pc, pl;
      cyc = 0; beats = 0; stalled = 0; pd = 0; pr = 0; pc = 0; pl = 0;
      while (sb_a.size() > 0 && beats < stop_beats && cyc < 200) begin
         @(negedge clk);
         cyc++;
         a_cap_valid = inject && (cyc == 3 || sb_a.size() == 1);
         if (a_cap_valid)
            for (int i = 0; i < 16; i++) a_c_flat[i*32 +: 32] = 32'h0BAD_0000 + i;
         if (cyc == 1) begin
            chk("a_first_valid", a_out_valid, 1);
            chk("a_busy_stream", a_busy, 1);
            chk("a_cap_ready_stream", a_cap_ready, 0);
         end
         if (stalled) begin
            chk("a_stall_data", a_out_data, pd);
            chk("a_stall_row", a_out_row, pr);
            chk("a_stall_col", a_out_col, pc);
            chk("a_stall_last", a_out_last, pl);
         end
         rdy = stall_pat ? (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3)) : 1'b1;
         a_out_ready = rdy;
         if (a_out_valid && rdy) begin
            e = sb_a.pop_front();
            chk("a_data", a_out_data, e.data);
            chk("a_row", a_out_row, e.row);
            chk("a_col", a_out_col, e.col);
            chk("a_last", a_out_last, e.last);
            beats++;
            stalled = 0;
         end else begin
            stalled = a_out_valid;
            pd = a_out_data; pr = a_out_row; pc = a_out_col; pl = a_out_last;
         end
      end
   endtask

   task automatic check_a_idle(input string tag);
      @(negedge clk);
      a_cap_valid = 1'b0;
      chk({tag, "_cap_ready"}, a_cap_ready, 1);
      chk({tag, "_out_valid"}, a_out_valid, 0);
      chk({tag, "_busy"}, a_busy, 0);
      chk({tag, "_sb_left"}, sb_a.size(), 0);
   endtask

   initial begin
      int    cyc, beats;
      beat_t e;
      rst_n = 1'b0;
      a_cap_valid = 0; a_out_ready = 0; a_c_flat = '0;
      b_cap_valid = 0; b_out_ready = 0; b_c_flat = '0;
      c_cap_valid = 0; c_out_ready = 0; c_c_flat = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_out_last", a_out_last, 0);
      chk("rst_out_data", a_out_data, 0);
      chk("rst_row", a_out_row, 0);
      chk("rst_col", a_out_col, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cap_ready", a_cap_ready, 1);

      // Full drain, out_ready held high: values 0..15 on 16 consecutive cycles
      load_a(0, 1);
      cap_a();
      drain_a(0, 0, 16, cyc, beats);
      chk("t1_cycles", cyc, 16);
      chk("t1_beats", beats, 16);
      check_a_idle("t1_idle");

      // Stall pattern with mixed-sign data
      load_a(-5000, 997);
      cap_a();
      drain_a(1, 0, 16, cyc, beats);
      chk("t2_beats", beats, 16);
      check_a_idle("t2_idle");

      // cap_valid pulses and c_flat changes while streaming are ignored
      load_a(42, -13);
      cap_a();
      drain_a(0, 1, 16, cyc, beats);
      chk("t3_beats", beats, 16);
      check_a_idle("t3_idle");

      // Reset after beat 5 abandons the matrix
      load_a(7, 3);
      cap_a();
      drain_a(0, 0, 5, cyc, beats);
      chk("t4_beats_before_rst", beats, 5);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t4_rst_out_valid", a_out_valid, 0);
      chk("t4_rst_busy", a_busy, 0);
      chk("t4_rst_out_last", a_out_last, 0);
      chk("t4_rst_out_data", a_out_data, 0);
      sb_a.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t4_post_cap_ready", a_cap_ready, 1);
      chk("t4_post_out_valid", a_out_valid, 0);
      load_a(1000, -100);
      cap_a();
      drain_a(0, 0, 16, cyc, beats);
      chk("t5_beats", beats, 16);
      check_a_idle("t5_idle");

      // Instance B: rounding and saturation
      b_c_flat[0*32 +: 32] = 32'sd6;
      b_c_flat[1*32 +: 32] = -32'sd6;
      b_c_flat[2*32 +: 32] = 32'sd1000;
      b_c_flat[3*32 +: 32] = -32'sd1000;
      sb_b.push_back('{data: 2,    row: 0, col: 0, last: 0});
      sb_b.push_back('{data: -1,   row: 0, col: 1, last: 0});
      sb_b.push_back('{data: 127,  row: 0, col: 2, last: 0});
      sb_b.push_back('{data: -128, row: 0, col: 3, last: 1});
      @(negedge clk);
      b_cap_valid = 1'b1;
      for (int k = 0; k < 10 && sb_b.size() > 0; k++) begin
         @(negedge clk);
         b_cap_valid = 1'b0;
         b_out_ready = 1'b1;
         if (b_out_valid) begin
            e = sb_b.pop_front();
            chk("b_data", b_out_data, e.data);
            chk("b_col", b_out_col, e.col);
            chk("b_last", b_out_last, e.last);
         end
      end
      chk("b_sb_left", sb_b.size(), 0);

      // Instance C: single row, three columns
      c_c_flat[0*16 +: 16] = 16'sd100;
      c_c_flat[1*16 +: 16] = -16'sd200;
      c_c_flat[2*16 +: 16] = 16'sd300;
      sb_c.push_back('{data: 100,  row: 0, col: 0, last: 0});
      sb_c.push_back('{data: -200, row: 0, col: 1, last: 0});
      sb_c.push_back('{data: 300,  row: 0, col: 2, last: 1});
      @(negedge clk);
      c_cap_valid = 1'b1;
      for (int k = 0; k < 10 && sb_c.size() > 0; k++) begin
         @(negedge clk);
         c_cap_valid = 1'b0;
         c_out_ready = 1'b1;
         if (c_out_valid) begin
            e = sb_c.pop_front();
            chk("c_data", c_out_data, e.data);
            chk("c_row", c_out_row, e.row);
            chk("c_col", c_out_col, e.col);
            chk("c_last", c_out_last, e.last);
         end
      end
      chk("c_sb_left", sb_c.size(), 0);
      @(negedge clk);
      chk("c_idle_out_valid", c_out_valid, 0);
      chk("c_idle_cap_ready", c_cap_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sa_output_drain.md
SA_OUTPUT_DRAIN -- requirements
Module: sa_output_drain

Interface
REQ-001 SHALL have parameter M, default 4, number of result rows.
REQ-002 SHALL have parameter N, default 4, number of result columns.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, signed accumulator width from the systolic array.
REQ-004 SHALL have parameter OUT_WIDTH, default 8, signed output element width.
REQ-005 SHALL have parameter SHIFT, default 0, requantization right-shift amount (0..ACC_WIDTH-1).
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port cap_valid  input  1  array asserts when its C matrix is final.
REQ-009 SHALL have port cap_ready  output  1  block can accept a new C matrix.
REQ-010 SHALL have port c_flat  input  M*N*ACC_WIDTH  signed C matrix, element (r,c) at index r*N+c, element 0 in LSBs.
REQ-011 SHALL have port out_valid  output  1  out_data holds a valid element.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the element.
REQ-013 SHALL have port out_data  output  OUT_WIDTH  requantized signed element.
REQ-014 SHALL have port out_row  output  clog2(M)  row index of out_data.
REQ-015 SHALL have port out_col  output  clog2(N)  column index of out_data.
REQ-016 SHALL have port out_last  output  1  high with the element (M-1,N-1).
REQ-017 SHALL have port busy  output  1  high while a captured matrix is not fully drained.

Function
REQ-018 SHALL implement FSM with states IDLE and STREAM.
REQ-019 IDLE: cap_ready=1, out_valid=0; on cap_valid&&cap_ready SHALL register all of c_flat into an internal M*N buffer, clear row/col counters, go to STREAM next cycle.
REQ-020 STREAM: cap_ready=0, out_valid=1, busy=1; out_data/out_row/out_col SHALL reflect buffer element at current (row,col).
REQ-021 First out_valid SHALL appear exactly one cycle after the capture handshake.
REQ-022 A beat SHALL transfer only on out_valid&&out_ready; counters advance row-major (col increments, wraps to 0 at N-1 with row increment).
REQ-023 While out_valid=1 and out_ready=0, out_data, out_row, out_col, out_last SHALL hold stable.
REQ-024 On transfer of the out_last beat SHALL return to IDLE; cap_ready high the following cycle (no capture overlaps the last beat).
REQ-025 cap_valid SHALL be ignored in STREAM; c_flat changes there SHALL not affect buffered data.
REQ-026 Requantization: if SHIFT>0, add 2^(SHIFT-1) then arithmetic right shift by SHIFT (round half up); if SHIFT=0 pass through; computed in ACC_WIDTH+1 bits to avoid overflow.
REQ-027 Result SHALL saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-028 Exactly M*N beats SHALL be produced per capture; full drain with out_ready held high takes M*N cycles.
REQ-029 M=1 or N=1 SHALL be supported (index port width minimum 1 bit).

Reset
REQ-030 reset_n low SHALL immediately force IDLE, cap_ready=1 after release, out_valid=0, out_last=0, busy=0, counters 0, out_data=0.
REQ-031 Reset asserted mid-STREAM SHALL abandon the matrix; no further beats of it appear.
REQ-032 Buffer contents need not be reset.

Structure
REQ-033 State encoding typedef and requantize/saturate function SHALL live in shared package gemm_pkg.
REQ-034 SHALL be one module with no submodules; requantize is a package function, not a sub-module.

Verification
REQ-035 M=N=4, SHIFT=0, OUT_WIDTH=32, C(r,c)=r*4+c, out_ready=1 -> 16 beats on consecutive cycles, values 0..15, out_last only on beat 15, cap_ready high cycle after.
REQ-036 SHIFT=2, OUT_WIDTH=8, elements 6, -6, 1000, -1000 -> out_data 2, -1, 127, -128.
REQ-037 out_ready toggled 1,0,0,1 pattern -> no lost or duplicated elements, outputs stable during stalls, order row-major.
REQ-038 cap_valid pulsed with different c_flat during STREAM -> ignored; drained values equal first capture.
REQ-039 reset_n low after beat 5 of 16 -> out_valid=0 immediately, busy=0; new capture after release drains from (0,0).
REQ-040 M=1, N=3 -> 3 beats, out_row=0, out_col 0,1,2, out_last on third.
